// File: rtl/ql_dsp_cfg_loader.sv
// Serial configuration loader for one fracturable DSP tile.
// Hunts for a sync header and shifts the payload into a shadow register.
// The live controls load from the shadow register in a single cycle,
// and only after the frame's even-parity bit checks out.
module ql_dsp_cfg_loader #(
   parameter int          NBITS_A = 20,
   parameter int          NCFG    = 14 + 4*NBITS_A,
   parameter logic [7:0]  HDR     = 8'hA5
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               cfg_data_i,
   input  logic               cfg_valid_i,
   output logic               cfg_ready_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               f_mode_o,
   output logic [2:0]         output_select_o,
   output logic               saturate_enable_o,
   output logic [5:0]         shift_right_o,
   output logic               round_o,
   output logic               subtract_o,
   output logic               register_inputs_o,
   output logic [NBITS_A-1:0] coef_0_o,
   output logic [NBITS_A-1:0] coef_1_o,
   output logic [NBITS_A-1:0] coef_2_o,
   output logic [NBITS_A-1:0] coef_3_o
);

   localparam int CW = $clog2(NCFG);

   typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY, COMMIT} state_t;

   state_t            state;
   logic [7:0]        hdr_sr;
   logic [CW-1:0]     cnt;
   logic              par;
   logic [NCFG-1:0]   shadow;
   logic              xfer;
   logic [7:0]        hdr_nxt;

   // ready is registered, so a transfer is judged against the previous edge's view
   assign xfer    = cfg_valid_i & cfg_ready_o;
   assign hdr_nxt = {hdr_sr[6:0], cfg_data_i};

   // Frame FSM with registered status/handshake outputs and the live config bank
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state             <= HUNT;
         hdr_sr            <= '0;
         cnt               <= '0;
         par               <= 1'b0;
         shadow            <= '0;
         cfg_ready_o       <= 1'b0;
         busy_o            <= 1'b0;
         done_o            <= 1'b0;
         err_o             <= 1'b0;
         f_mode_o          <= 1'b0;
         output_select_o   <= '0;
         saturate_enable_o <= 1'b0;
         shift_right_o     <= '0;
         round_o           <= 1'b0;
         subtract_o        <= 1'b0;
         register_inputs_o <= 1'b0;
         coef_0_o          <= '0;
         coef_1_o          <= '0;
         coef_2_o          <= '0;
         coef_3_o          <= '0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            HUNT: begin
               // also re-arms ready on the first cycle out of reset
               cfg_ready_o <= 1'b1;
               if (xfer) begin
                  hdr_sr <= hdr_nxt;
                  if (hdr_nxt == HDR) begin
                     cnt    <= '0;
                     par    <= 1'b0;
                     busy_o <= 1'b1;
                     state  <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  shadow[cnt] <= cfg_data_i;
                  par         <= par ^ cfg_data_i;
                  cnt         <= cnt + 1'b1;
                  if (cnt == CW'(NCFG-1))
                     state <= PARITY;
               end
            end
            PARITY: begin
               if (xfer) begin
                  if (cfg_data_i == par) begin
                     cfg_ready_o <= 1'b0;
                     state       <= COMMIT;
                  end else begin
                     err_o  <= 1'b1;
                     hdr_sr <= '0;
                     busy_o <= 1'b0;
                     state  <= HUNT;
                  end
               end
            end
            COMMIT: begin
               // the only edge at which live controls may change
               f_mode_o          <= shadow[0];
               output_select_o   <= shadow[3:1];
               saturate_enable_o <= shadow[4];
               shift_right_o     <= shadow[10:5];
               round_o           <= shadow[11];
               subtract_o        <= shadow[12];
               register_inputs_o <= shadow[13];
               coef_0_o          <= shadow[14+0*NBITS_A +: NBITS_A];
               coef_1_o          <= shadow[14+1*NBITS_A +: NBITS_A];
               coef_2_o          <= shadow[14+2*NBITS_A +: NBITS_A];
               coef_3_o          <= shadow[14+3*NBITS_A +: NBITS_A];
               done_o            <= 1'b1;
               hdr_sr            <= '0;
               busy_o            <= 1'b0;
               cfg_ready_o       <= 1'b1;
               state             <= HUNT;
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_ql_dsp_cfg_loader.sv
// Scoreboard bench for ql_dsp_cfg_loader: each frame's expected outcome
// (commit or parity error, with its cycle) is queued once its parity bit
// transfers, and is retired when the loader reports done/err.
module tb_ql_dsp_cfg_loader;

   localparam int         NBITS_A = 20;
   localparam int         NCFG    = 14 + 4*NBITS_A;
   localparam logic [7:0] HDR     = 8'hA5;

   typedef struct {
      bit              is_err;
      logic [NCFG-1:0] p;
      int              cyc;
   } exp_t;

   logic clk, rst, cfg_data, cfg_valid;
   logic cfg_ready, busy, done, err;
   logic f_mode, sat, rnd, sub, reg_in;
   logic [2:0] osel;
   logic [5:0] shr;
   logic [NBITS_A-1:0] c0, c1, c2, c3;
   logic [NCFG-1:0] live_vec;

   exp_t            exp_q[$];
   int              done_cycs[$];
   logic [NCFG-1:0] last_cfg;
   int              tests, fails, cyc, ndone, nerr;
   bit              mon_en;

   ql_dsp_cfg_loader #(.NBITS_A(NBITS_A), .NCFG(NCFG), .HDR(HDR)) dut (
      .clock_i(clk), .reset_i(rst), .cfg_data_i(cfg_data), .cfg_valid_i(cfg_valid),
      .cfg_ready_o(cfg_ready), .busy_o(busy), .done_o(done), .err_o(err),
      .f_mode_o(f_mode), .output_select_o(osel), .saturate_enable_o(sat),
      .shift_right_o(shr), .round_o(rnd), .subtract_o(sub), .register_inputs_o(reg_in),
      .coef_0_o(c0), .coef_1_o(c1), .coef_2_o(c2), .coef_3_o(c3)
   );

   assign live_vec = {c3, c2, c1, c0, reg_in, sub, rnd, shr, sat, osel, f_mode};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Retire scoreboard entries on done/err and hold live outputs to the model
   always @(negedge clk) begin
      if (mon_en) begin
         if (done || err) begin
            if (exp_q.size() == 0) chk("unexpected_evt", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("evt_err", err, e.is_err);
               chk("evt_cyc", cyc, e.cyc);
               if (!e.is_err) begin
                  last_cfg = e.p;
                  done_cycs.push_back(cyc);
                  ndone++;
               end else nerr++;
            end
         end
         chk("live", live_vec, last_cfg);
      end
   end

   function automatic logic [NCFG-1:0] mk(bit fm, logic [2:0] os, bit st, logic [5:0] sh,
                                          bit rd, bit sb, bit ri, logic [19:0] k0,
                                          logic [19:0] k1, logic [19:0] k2, logic [19:0] k3);
      logic [NCFG-1:0] p;
      p = '0;
      p[0] = fm; p[3:1] = os; p[4] = st; p[10:5] = sh;
      p[11] = rd; p[12] = sb; p[13] = ri;
      p[14 +: 20] = k0; p[34 +: 20] = k1; p[54 +: 20] = k2; p[74 +: 20] = k3;
      return p;
   endfunction

   function automatic logic [NCFG-1:0] rnd_payload();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[NCFG-1:0];
   endfunction

   // Drive one bit (after an optional idle gap); returns cycles spent waiting on ready
   task automatic send_bit(input bit b, input int gap, output int w);
      if (gap > 0) begin
         cfg_valid = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
      cfg_valid = 1'b1;
      cfg_data  = b;
      w = 0;
      while (!cfg_ready) begin
         w++;
         if (w > 50) begin
            fails++;
            $display("FAIL ready_timeout obs=0 exp=1");
            $fatal(1, "ready never asserted");
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [NCFG-1:0] p, input bit bad, input int maxgap,
                             output int w0);
      int f, pc, gaps, g, w;
      exp_t e;
      gaps = 0;
      for (int i = 0; i < 8; i++) begin
         g = (i > 0 && maxgap > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, maxgap) : 0;
         gaps += g;
         send_bit(HDR[7-i], g, w);
         if (i == 0) begin w0 = w; f = cyc; end
         chk("hdr_busy", busy, (i == 7));
      end
      for (int i = 0; i < NCFG; i++) begin
         g = (maxgap > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, maxgap) : 0;
         gaps += g;
         send_bit(p[i], g, w);
      end
      g = (maxgap > 0) ? $urandom_range(1, maxgap) : 0;
      gaps += g;
      send_bit((^p) ^ bad, g, w);
      cfg_valid = 1'b0;
      pc = cyc;
      e.is_err = bad;
      e.p      = p;
      e.cyc    = bad ? pc : pc + 1;
      exp_q.push_back(e);
      chk("frm_len", pc - f, 8 + NCFG + gaps);
   endtask

   task automatic do_reset();
      mon_en    = 1'b0;
      cfg_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", cfg_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_live", live_vec, 0);
      last_cfg = '0;
      exp_q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
   endtask

   initial begin
      logic [NCFG-1:0] pa, pb, pc, pd, pe, pf, pg, ph;
      int w, w2, nd;
      tests = 0; fails = 0; cyc = 0; ndone = 0; nerr = 0;
      mon_en = 1'b0; rst = 1'b1; cfg_valid = 1'b0; cfg_data = 1'b0;
      last_cfg = '0;
      @(posedge clk); #1;
      do_reset();

      // basic load
      pa = mk(1, 3'b101, 0, 6'd17, 1, 0, 0, 20'h12345, 20'h0, 20'h0, 20'hABCDE);
      send_frame(pa, 0, 0, w);
      repeat (3) begin @(posedge clk); #1; end
      chk("f_mode", f_mode, 1);
      chk("osel", osel, 3'b101);
      chk("shr", shr, 17);
      chk("round", rnd, 1);
      chk("sat", sat, 0);
      chk("sub", sub, 0);
      chk("reg_in", reg_in, 0);
      chk("coef0", c0, 20'h12345);
      chk("coef1", c1, 0);
      chk("coef3", c3, 20'hABCDE);
      chk("basic_done", ndone, 1);
      chk("basic_err", nerr, 0);

      // bad parity: outputs keep frame A
      pb = rnd_payload();
      send_frame(pb, 1, 0, w);
      repeat (3) begin @(posedge clk); #1; end
      chk("bad_err", nerr, 1);
      chk("bad_done", ndone, 1);
      chk("bad_coef0", c0, 20'h12345);

      // garbage prefix before header
      foreach (pa[i]) if (i < 5) send_bit((5'b01011 >> i) & 1, 0, w);
      pc = rnd_payload();
      send_frame(pc, 0, 0, w);
      // payload carrying the header pattern as data
      pd = rnd_payload();
      for (int k = 0; k < 8; k++) pd[20+k] = HDR[7-k];
      send_frame(pd, 0, 0, w);
      repeat (3) begin @(posedge clk); #1; end
      chk("hunt_done", ndone, 3);

      // valid gaps
      pe = rnd_payload();
      send_frame(pe, 0, 5, w);
      repeat (3) begin @(posedge clk); #1; end
      chk("gap_done", ndone, 4);

      // reset after 50 payload bits
      for (int i = 0; i < 8; i++) send_bit(HDR[7-i], 0, w);
      pf = rnd_payload();
      for (int i = 0; i < 50; i++) send_bit(pf[i], 0, w);
      chk("mid_busy", busy, 1);
      do_reset();
      send_frame(pf, 0, 0, w);
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_reload", live_vec, pf);

      // back-to-back frames
      nd = ndone;
      pg = rnd_payload();
      ph = rnd_payload();
      send_frame(pg, 0, 0, w);
      send_frame(ph, 0, 0, w2);
      chk("b2b_ready_low", w2, 1);
      repeat (4) begin @(posedge clk); #1; end
      chk("b2b_done", ndone - nd, 2);
      if (done_cycs.size() >= 2)
         chk("b2b_spacing", done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2], 104);
      else
         chk("b2b_spacing", done_cycs.size(), 2);
      chk("q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ql_dsp_cfg_loader.md
# ql_dsp_cfg_loader

Serial configuration loader that produces the static mode and coefficient controls consumed by the fracturable DSP tile: f_mode, output_select, saturate, shift_right, round, subtract, register_inputs and the four coefficients. It accepts a framed bitstream over a 1-bit valid/ready stream and assembles the payload in a shadow register. The live configuration outputs update atomically, and only after the frame passes its parity check. It sits between the fabric configuration controller and one DSP tile.

## Interface
- NBITS_A, 20, coefficient width; equals the DSP A-operand width.
- NCFG, 14+4*NBITS_A, payload length in bits (94 by default).
- HDR, 8'hA5, 8-bit sync header.

Ports:
- clock_i  in  1  the only clock; all logic is on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- cfg_data_i  in  1  serial configuration bit.
- cfg_valid_i  in  1  cfg_data_i is valid.
- cfg_ready_o  out  1  loader accepts a bit; a bit transfers on any edge where valid && ready.
- busy_o  out  1  a frame is in progress (any state other than HUNT).
- done_o  out  1  one-cycle pulse when a frame commits.
- err_o  out  1  one-cycle pulse when a frame is discarded on parity failure.
- f_mode_o  out  1  live configuration field.
- output_select_o  out  3  live configuration field.
- saturate_enable_o  out  1  live configuration field.
- shift_right_o  out  6  live configuration field.
- round_o  out  1  live configuration field.
- subtract_o  out  1  live configuration field.
- register_inputs_o  out  1  live configuration field.
- coef_0_o..coef_3_o  out  NBITS_A each  live coefficients.

## Operation
- Frame format, in transfer order: 8 header bits, then NCFG payload bits, then 1 parity bit.
  - The header is sent MSB first, so HDR = 1,0,1,0,0,1,0,1.
  - The payload is sent LSB first (payload bit 0 first).
  - The parity bit is even parity: it equals the XOR of all payload bits.
- Payload map:
  - [0] f_mode
  - [3:1] output_select
  - [4] saturate_enable
  - [10:5] shift_right
  - [11] round
  - [12] subtract
  - [13] register_inputs
  - [14+:NBITS_A] coef_0, then coef_1, coef_2, coef_3 in consecutive NBITS_A slices.
- State machine:
  - **HUNT**: on each transfer, hdr_sr <= {hdr_sr[6:0], bit}. If the updated value equals HDR, clear the bit counter and running parity, then go to PAYLOAD.
  - **PAYLOAD**: on each transfer, write the bit into shadow[cnt], XOR it into the running parity and increment cnt. The transfer with cnt == NCFG-1 moves to PARITY.
  - **PARITY**: on the transfer, compare the received bit with the running parity.
    - Match: go to COMMIT.
    - Mismatch: pulse err_o next cycle, clear hdr_sr, go to HUNT.
  - **COMMIT**: lasts exactly one cycle. All live outputs load from shadow at the edge that ends COMMIT. done_o is high in the following cycle. hdr_sr clears and the state returns to HUNT.
- The header is searched for only in HUNT. Header patterns inside the payload are treated as data.
- cfg_ready_o is 1 in HUNT, PAYLOAD and PARITY, and 0 in COMMIT and while reset_i is high.
- Cycles with cfg_valid_i low do not advance any state, counter or shift register.
- Live outputs never change except at the COMMIT edge and on reset. Partial and failed frames leave them untouched.
- Reset while reset_i is high:
  - state = HUNT, hdr_sr = 0, cnt = 0, running parity = 0, shadow = 0.
  - All live outputs = 0.
  - busy_o = done_o = err_o = 0.
  - This applies mid-frame; the partial frame is lost.

## Timing
- Every output is registered; there is no combinational path from inputs to outputs.
- Minimum frame length is 8+NCFG+1 = 103 transfers, plus 1 COMMIT cycle.
- Latency: the parity bit is accepted at edge N. The state is COMMIT during cycle N→N+1. Live outputs change at edge N+1. done_o is high during N+1→N+2.
- Back-to-back frames: the first header bit of the next frame may transfer at edge N+2, in the first HUNT cycle after COMMIT.
- On a parity failure, err_o is high for the cycle after the parity edge, and HUNT accepts bits in that same cycle.
- busy_o rises the cycle after the final header bit and falls the cycle after COMMIT or after the parity-fail edge.

## Test plan
- **Basic load**: reset, then send HDR and a payload with f_mode=1, output_select=3'b101, shift_right=6'd17, round=1, coef_0=20'h12345, coef_3=20'hABCDE, all other fields 0, with correct parity and valid held high.
  - Outputs show exactly these values at the edge after COMMIT.
  - done_o pulses once; err_o stays 0.
- **Bad parity**: load a good frame, then send a second frame with its parity bit inverted.
  - err_o pulses once.
  - All outputs keep the first frame's values; done_o stays 0.
- **Header hunt**: send the garbage prefix 1,1,0,1,0 immediately before HDR.
  - Header lock occurs on the final HDR bit, and the frame commits correctly.
  - Also send a payload that contains 0xA5 internally; it loads as data with no resync.
- **Valid gaps**: drop cfg_valid_i for 1–5 random cycles between bits.
  - Result is identical to the gap-free run; commit is delayed by the total idle cycles.
- **Reset mid-frame**: assert reset_i for one cycle after 50 payload bits.
  - All outputs go to 0, busy_o goes to 0, and cfg_ready_o is 0 during reset.
  - A fresh full frame afterwards loads correctly.
- **Back-to-back frames**: send frame A then frame B with no idle cycles.
  - cfg_ready_o is low for exactly one cycle between them.
  - The outputs equal A for 104 cycles, then equal B; done_o pulses twice.
